// File: rtl/hack_alu_pkg.sv
// -----------------------------------------------------------------------------
// hack_alu_pkg
// Shared types and constants for the hack_n2t arithmetic path.
//   serial_add_state_t : sequencer states of the bit-serial adder
//   OP_ADD / OP_SUB    : encoding of the op_sub request field
// -----------------------------------------------------------------------------
package hack_alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_add_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : hack_alu_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder used as the bit slice of serial_add_seq.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop_s;

    assign prop_s = a ^ b;
    assign sum    = prop_s ^ cin;
    assign cout   = (a & b) | (cin & prop_s);

endmodule : full_adder

// File: rtl/serial_add_seq.sv
// -----------------------------------------------------------------------------
// serial_add_seq
// Bit-serial add/subtract sequencer. A single full_adder is stepped over WIDTH
// cycles, LSB first, with a carry flip-flop linking consecutive bits.
// Subtraction is A + ~B + 1: the inverted B is latched and the carry flip-flop
// is preset to 1 at accept.
//
// Ports:
//   clk, rst_n               : clock (rising edge), async active-low reset
//   abort                    : (only with SERIAL_ADD_SEQ_ABORT_EN) discard the
//                              operation in flight
//   start_valid/start_ready  : request handshake carrying op_a, op_b, op_sub
//   res_valid/res_ready      : result handshake
//   result                   : sum / difference (modulo 2^WIDTH)
//   carry_out                : carry out of the MSB (subtract: 1 = no borrow)
//   overflow                 : signed overflow
//   zero, neg                : result == 0, result MSB (0 unless res_valid)
//   busy                     : sequencer not idle
//
// Optional feature macro: SERIAL_ADD_SEQ_ABORT_EN adds the abort input.
// -----------------------------------------------------------------------------
module serial_add_seq
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADD_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             neg,
    output logic             busy
);

    serial_add_state_t state_r;
    serial_add_state_t state_nx_s;

    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_nx_s;
    logic             cy_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             zero_r;
    logic             neg_r;
    logic             sum_s;
    logic             carry_s;
    logic             last_bit_s;
    logic             abort_s;

`ifdef SERIAL_ADD_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    full_adder u_full_adder (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (cy_r),
        .sum  (sum_s),
        .cout (carry_s)
    );

    // The edge where cnt == WIDTH-1 consumes the operand MSBs.
    assign last_bit_s  = (cnt_r == CNT_W'(WIDTH - 1));
    assign result_nx_s = {sum_s, result_r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort wins over res_ready, and DONE never accepts.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (abort_s) begin
                    state_nx_s = IDLE;
                end else if (last_bit_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                if (abort_s || res_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry flip-flop, bit counter and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r      <= {WIDTH{1'b0}};
            b_sr_r      <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            cy_r        <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        a_sr_r <= op_a;
                        b_sr_r <= (op_sub == OP_SUB) ? ~op_b : op_b;
                        cy_r   <= op_sub;
                        cnt_r  <= {CNT_W{1'b0}};
                        zero_r <= 1'b0;
                        neg_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort_s) begin
                        cy_r  <= 1'b0;
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                        b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                        result_r <= result_nx_s;
                        cy_r     <= carry_s;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        if (last_bit_s) begin
                            // cy_r is the carry into the MSB here.
                            carry_out_r <= carry_s;
                            overflow_r  <= cy_r ^ carry_s;
                            zero_r      <= (result_nx_s == {WIDTH{1'b0}});
                            neg_r       <= sum_s;
                            cnt_r       <= {CNT_W{1'b0}};
                        end
                    end
                end
                DONE: begin
                    if (abort_s) begin
                        cy_r   <= 1'b0;
                        cnt_r  <= {CNT_W{1'b0}};
                        zero_r <= 1'b0;
                        neg_r  <= 1'b0;
                    end else if (res_ready) begin
                        zero_r <= 1'b0;
                        neg_r  <= 1'b0;
                    end
                end
                default: begin
                    cy_r  <= 1'b0;
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign start_ready = (state_r == IDLE);
    assign res_valid   = (state_r == DONE);
    assign busy        = (state_r != IDLE);
    assign result      = result_r;
    assign carry_out   = carry_out_r;
    assign overflow    = overflow_r;
    assign zero        = zero_r;
    assign neg         = neg_r;

endmodule : serial_add_seq

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial add/subtract sequencer for the hack_n2t arithmetic path.
- Instantiates a single one-bit full_adder and drives it through WIDTH cycles, LSB first.
- A registered carry flip-flop links consecutive bits.
- Accepts an operation over a valid/ready handshake and returns the result with status flags over a second valid/ready handshake.
- Serves as the area-minimal alternative to a ripple-carry ALU adder.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  request carries a valid operation.
- start_ready  output  1  block can accept a request.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_sub  input  1  0 = A+B, 1 = A-B.
- res_valid  output  1  result and flags valid.
- res_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  carry out of MSB. For subtract, 1 = no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].
- busy  output  1  state != IDLE.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- During reset (all fields zero):
  - state = IDLE.
  - start_ready = 1 after release; res_valid = 0.
  - result, carry_out, overflow, zero, neg = 0; busy = 0.
  - Internal shift registers, carry flip-flop and counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready = 1.
  - On an edge with start_valid=1, the request is accepted:
    - A_sr <= op_a.
    - B_sr <= op_sub ? ~op_b : op_b.
    - cy <= op_sub.
    - cnt <= 0.
    - state <= SHIFT.
  - Operands are latched at accept; later input changes are ignored.
- SHIFT:
  - The full_adder receives a=A_sr[0], b=B_sr[0], cin=cy.
  - Each edge:
    - A_sr and B_sr shift right.
    - The sum bit is shifted into the MSB of the result register (result shifts right).
    - cy <= carry.
    - cnt++.
  - When cnt == WIDTH-1 that edge processes the MSB:
    - carry_out <= carry.
    - overflow <= cy ^ carry (carry into the MSB XOR carry out of it).
    - state <= DONE.
- DONE:
  - res_valid = 1.
  - result and all flags are stable while res_valid=1 and res_ready=0.
  - zero and neg are derived from the final result register. They are valid whenever res_valid=1 and remain 0 otherwise.
  - On an edge with res_ready=1, state <= IDLE and res_valid drops.
- result and flags are meaningful only while res_valid=1. The result register may show partial values during SHIFT.
- Latency and throughput:
  - The accept edge is T0; bits are processed at edges T0+1 through T0+WIDTH.
  - res_valid is high in the cycle after edge T0+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles (no accept in DONE).
- start_ready = 0 in SHIFT and DONE. start_valid there is ignored and not queued.
- Simultaneous res_ready and start_valid in DONE: only the result handshake completes. The new request is accepted in IDLE the following cycle.
- Wrap-around: the adder wraps modulo 2^WIDTH; the overflow and carry flags report it. No saturation.
- Reset mid-operation: immediate return to the reset state; the partial result is discarded.

Optional Feature:
- Macro: SERIAL_ADD_SEQ_ABORT_EN.
- With the macro defined:
  - Extra port abort (input, 1).
  - abort=1 at an edge in SHIFT or DONE: state <= IDLE, res_valid <= 0, carry flip-flop and counter cleared, operation discarded.
  - abort has priority over res_ready in DONE.
  - abort in IDLE has no effect and does not block an accept on the same edge.
- Without the macro: no abort port; an operation always runs to DONE.

Decomposition:
- Package hack_alu_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} serial_add_state_t.
  - Operation encoding constants OP_ADD=1'b0 and OP_SUB=1'b1.
- Sub-module: one instance of full_adder for the bit slice. All sequencing, shift registers and flags stay in serial_add_seq.

Test Plan:
- WIDTH=16 add, 0x0003+0x0004 -> result 0x0007, carry_out 0, overflow 0, zero 0, neg 0; res_valid rises exactly 16 edges after the accept edge.
- Add 0x7FFF+0x0001 -> 0x8000, overflow 1, neg 1, carry_out 0. Add 0xFFFF+0x0001 -> 0x0000, carry_out 1, zero 1, overflow 0.
- Sub 0x0005-0x0005 -> 0x0000, zero 1, carry_out 1. Sub 0x0000-0x0001 -> 0xFFFF, carry_out 0, neg 1, overflow 0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while toggling start_valid and the operands -> result and flags unchanged, start_ready 0, no second accept. After res_ready=1, IDLE next cycle.
- Reset: assert rst_n=0 during SHIFT after 7 bits -> all outputs 0 immediately. After release, start_ready=1 and a fresh 0x1234+0x1111 returns 0x2345.
- With SERIAL_ADD_SEQ_ABORT_EN: abort at the 4th SHIFT cycle -> IDLE next edge, res_valid never asserted. The next 0x0001+0x0001 returns 0x0002.
